// File: rtl/pc_unit_if.sv
// Fetch-stage bus between the pipeline control and pc_unit.
// Exception signals (exc_req/epc) exist only when PC_EXC_EN is defined.
interface pc_unit_if #(
  parameter int WIDTH = 32,
  parameter int IMM_W = 16
);
  logic             stall;
  logic             br_taken;
  logic [IMM_W-1:0] br_imm;
  logic             jump;
  logic [25:0]      jmp_target;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus;
  logic             pc_valid;
  logic             flush;
  logic             misalign;
`ifdef PC_EXC_EN
  logic             exc_req;
  logic [WIDTH-1:0] epc;
`endif

  modport master (
    output stall, br_taken, br_imm, jump, jmp_target,
`ifdef PC_EXC_EN
    output exc_req, input epc,
`endif
    input  pc, pc_plus, pc_valid, flush, misalign
  );

  modport slave (
    input  stall, br_taken, br_imm, jump, jmp_target,
`ifdef PC_EXC_EN
    input  exc_req, output epc,
`endif
    output pc, pc_plus, pc_valid, flush, misalign
  );
endinterface

// File: rtl/pc_unit.sv
// Program-counter unit for the mips fetch stage: next-PC selection plus a
// BOOT/RUN/HOLD/FLUSH validity FSM. Optional exception redirect: PC_EXC_EN.
module pc_unit #(
  parameter int               WIDTH     = 32,
  parameter int               STEP      = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter int               IMM_W     = 16
`ifdef PC_EXC_EN
  ,
  parameter logic [WIDTH-1:0] EXC_VEC   = 32'h0000_0180
`endif
) (
  input  logic     clk,
  input  logic     rst_n,
  pc_unit_if.slave bus
);

  typedef enum logic [1:0] {BOOT, RUN, HOLD, FLUSH} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] pc_reg;
  logic             pc_valid_reg;
  logic             flush_reg;
  logic             misalign_reg;
`ifdef PC_EXC_EN
  logic [WIDTH-1:0] epc_reg;
`endif

  logic [WIDTH-1:0] pc_plus_w;
  logic [WIDTH-1:0] br_offset;
  logic [WIDTH-1:0] branch_target;
  logic [WIDTH-1:0] jump_target;
  logic             redirect_next;
  logic [WIDTH-1:0] target_next;

  assign pc_plus_w = pc_reg + WIDTH'(STEP);

  // Word offset sign-extended and scaled by 4; bits beyond the immediate
  // replicate its sign bit.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_off
      if (gi < 2) begin : g_zero
        assign br_offset[gi] = 1'b0;
      end else if (gi - 2 < IMM_W) begin : g_imm
        assign br_offset[gi] = bus.br_imm[gi-2];
      end else begin : g_sign
        assign br_offset[gi] = bus.br_imm[IMM_W-1];
      end
    end

    if (WIDTH > 28) begin : g_jmp_region
      assign jump_target = {pc_plus_w[WIDTH-1:28], bus.jmp_target, 2'b00};
    end else begin : g_jmp_flat
      assign jump_target = {bus.jmp_target, 2'b00};
    end
  endgenerate

  assign branch_target = pc_plus_w + br_offset;

  always_comb begin
    redirect_next = bus.jump | bus.br_taken;
    target_next   = bus.jump ? jump_target : branch_target;
`ifdef PC_EXC_EN
    if (bus.exc_req) begin
      redirect_next = 1'b1;
      target_next   = EXC_VEC;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= BOOT;
      pc_reg       <= RESET_VEC;
      pc_valid_reg <= 1'b0;
      flush_reg    <= 1'b0;
      misalign_reg <= 1'b0;
`ifdef PC_EXC_EN
      epc_reg      <= '0;
`endif
    end else begin
      case (state_reg)
        BOOT: begin
          state_reg    <= RUN;
          pc_valid_reg <= 1'b1;
          flush_reg    <= 1'b0;
        end
        default: begin
          if (redirect_next) begin
            pc_reg <= {target_next[WIDTH-1:2], 2'b00};
            if (|target_next[1:0]) misalign_reg <= 1'b1;
`ifdef PC_EXC_EN
            if (bus.exc_req) epc_reg <= pc_reg;
`endif
            state_reg    <= FLUSH;
            pc_valid_reg <= 1'b0;
            flush_reg    <= 1'b1;
          end else if (bus.stall) begin
            state_reg    <= HOLD;
            pc_valid_reg <= 1'b1;
            flush_reg    <= 1'b0;
          end else begin
            // After a bubble the redirect target itself is fetched next.
            if (state_reg != FLUSH) pc_reg <= pc_plus_w;
            state_reg    <= RUN;
            pc_valid_reg <= 1'b1;
            flush_reg    <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.pc       = pc_reg;
  assign bus.pc_plus  = pc_plus_w;
  assign bus.pc_valid = pc_valid_reg;
  assign bus.flush    = flush_reg;
  assign bus.misalign = misalign_reg;
`ifdef PC_EXC_EN
  assign bus.epc      = epc_reg;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios with literal checks,
// then randomized traffic compared every cycle against a behavioural model.
module tb_pc_unit;
  localparam int WIDTH = 32;
  localparam int IMM_W = 16;
  localparam int STEP  = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pc_unit_if #(.WIDTH(WIDTH), .IMM_W(IMM_W)) bus ();

  pc_unit #(
    .WIDTH(WIDTH), .STEP(STEP), .RESET_VEC(32'h0), .IMM_W(IMM_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the pc, whether the boot edge is still pending,
  // and whether the current cycle is a post-redirect bubble.
  logic [31:0] m_pc     = 32'h0;
  logic [31:0] m_epc    = 32'h0;
  bit          m_boot   = 1'b1;
  bit          m_bubble = 1'b0;
  bit          m_mis    = 1'b0;

  always @(negedge rst_n) begin
    m_pc = 32'h0; m_epc = 32'h0; m_boot = 1'b1; m_bubble = 1'b0; m_mis = 1'b0;
  end

  always @(posedge clk) begin
    logic [31:0] plus, tgt;
    bit redir, exc;
    int off;
    if (rst_n === 1'b1) begin
      plus  = m_pc + STEP;
      redir = 1'b0;
      exc   = 1'b0;
      tgt   = 32'h0;
`ifdef PC_EXC_EN
      exc = bus.exc_req;
`endif
      if (m_boot) begin
        m_boot = 1'b0;
      end else begin
        if (exc) begin
          redir = 1'b1; tgt = 32'h0000_0180; m_epc = m_pc;
        end else if (bus.jump) begin
          redir = 1'b1; tgt = {plus[31:28], bus.jmp_target, 2'b00};
        end else if (bus.br_taken) begin
          off   = int'($signed(bus.br_imm));
          redir = 1'b1; tgt = plus + 32'(off * 4);
        end
        if (redir) begin
          if (tgt[1:0] != 2'b00) m_mis = 1'b1;
          m_pc     = tgt & ~32'h3;
          m_bubble = 1'b1;
        end else begin
          if (!bus.stall && !m_bubble) m_pc = plus;
          m_bubble = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("pc",       bus.pc,              m_pc);
    chk("pc_plus",  bus.pc_plus,         m_pc + STEP);
    chk("pc_valid", 32'(bus.pc_valid),   32'(!m_boot && !m_bubble));
    chk("flush",    32'(bus.flush),      32'(m_bubble));
    chk("misalign", 32'(bus.misalign),   32'(m_mis));
`ifdef PC_EXC_EN
    chk("epc",      bus.epc,             m_epc);
`endif
  end

  // Inputs change 1 time unit after the falling edge; outputs are read there too.
  task automatic step(input bit s, input bit b, input logic [15:0] imm,
                      input bit j, input logic [25:0] t);
    bus.stall = s; bus.br_taken = b; bus.br_imm = imm;
    bus.jump = j; bus.jmp_target = t;
`ifdef PC_EXC_EN
    bus.exc_req = 1'b0;
`endif
    @(negedge clk); #1;
  endtask

  task automatic lit(input string name, input logic [31:0] e_pc, input bit e_v, input bit e_f);
    chk({name, ".pc"},    bus.pc,            e_pc);
    chk({name, ".valid"}, 32'(bus.pc_valid), 32'(e_v));
    chk({name, ".flush"}, 32'(bus.flush),    32'(e_f));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.stall = 0; bus.br_taken = 0; bus.br_imm = '0; bus.jump = 0; bus.jmp_target = '0;
`ifdef PC_EXC_EN
    bus.exc_req = 1'b0;
`endif
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    // Boot then sequential increment.
    lit("rst", 32'h0, 0, 0);
    chk("rst.misalign", 32'(bus.misalign), 32'h0);
    step(0, 0, 16'h0, 0, 26'h0); lit("boot", 32'h0, 1, 0);
    step(0, 0, 16'h0, 0, 26'h0); lit("inc1", 32'h4, 1, 0);
    step(0, 0, 16'h0, 0, 26'h0); lit("inc2", 32'h8, 1, 0);
    step(0, 0, 16'h0, 0, 26'h0); lit("inc3", 32'hC, 1, 0);

    // Branch to 0x40, then backward branch by -2 words.
    step(0, 1, 16'd12, 0, 26'h0);  lit("br40", 32'h40, 0, 1);
    step(0, 0, 16'h0, 0, 26'h0);   lit("run40", 32'h40, 1, 0);
    step(0, 1, 16'hFFFE, 0, 26'h0); lit("brback", 32'h3C, 0, 1);
    step(0, 0, 16'h0, 0, 26'h0);   lit("tgt3c", 32'h3C, 1, 0);
    step(0, 0, 16'h0, 0, 26'h0);   lit("inc40", 32'h40, 1, 0);

    // Stall at 0x20, then a branch overriding the stall.
    step(0, 1, 16'hFFF7, 0, 26'h0); lit("br20", 32'h20, 0, 1);
    step(0, 0, 16'h0, 0, 26'h0);   lit("run20", 32'h20, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 16'h0, 0, 26'h0); lit("stall20", 32'h20, 1, 0);
    end
    step(1, 1, 16'h0001, 0, 26'h0); lit("brstall", 32'h28, 0, 1);
    step(0, 0, 16'h0, 0, 26'h0);   lit("run28", 32'h28, 1, 0);

    // Jumps, including jump+branch where the jump must win.
    step(0, 0, 16'h0, 1, 26'h3FF_FFFF); lit("jmpfff", 32'h0FFF_FFFC, 0, 1);
    step(0, 1, 16'h0005, 1, 26'h000_0004); lit("jmprgn", 32'h1000_0010, 0, 1);
    step(0, 0, 16'h0, 0, 26'h0);   lit("run10", 32'h1000_0010, 1, 0);
    step(0, 1, 16'h0005, 1, 26'h000_0100); lit("jmpwin", 32'h1000_0400, 0, 1);
    step(1, 0, 16'h0, 0, 26'h0);   lit("hold1", 32'h1000_0400, 1, 0);
    step(1, 0, 16'h0, 0, 26'h0);   lit("hold2", 32'h1000_0400, 1, 0);

    // Asynchronous reset in HOLD takes effect before the next clock edge.
    #2 rst_n = 1'b0;
    #1 lit("async", 32'h0, 0, 0);
    @(negedge clk); #1 rst_n = 1'b1;
    step(0, 0, 16'h0, 0, 26'h0);   lit("reboot", 32'h0, 1, 0);

    // Wrap from all-ones back to zero.
    step(0, 1, 16'hFFFE, 0, 26'h0); lit("brtop", 32'hFFFF_FFFC, 0, 1);
    step(0, 0, 16'h0, 0, 26'h0);   lit("top", 32'hFFFF_FFFC, 1, 0);
    chk("wrap.pc_plus", bus.pc_plus, 32'h0);
    step(0, 0, 16'h0, 0, 26'h0);   lit("wrap", 32'h0, 1, 0);
    chk("wrap.misalign", 32'(bus.misalign), 32'h0);

`ifdef PC_EXC_EN
    step(0, 1, 16'h0021, 0, 26'h0); lit("br88", 32'h88, 0, 1);
    step(0, 0, 16'h0, 0, 26'h0);   lit("run88", 32'h88, 1, 0);
    bus.exc_req = 1'b1; bus.jump = 1'b1; bus.jmp_target = 26'h123;
    @(negedge clk); #1;
    lit("exc", 32'h180, 0, 1);
    chk("exc.epc", bus.epc, 32'h88);
    step(0, 0, 16'h0, 0, 26'h0);   lit("run180", 32'h180, 1, 0);
`endif

    // Randomized traffic; the per-cycle compare process checks the model.
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 199);
      if (r == 0) begin
        rst_n = 1'b0;
        step(0, 0, 16'h0, 0, 26'h0);
        rst_n = 1'b1;
      end else begin
        bus.stall      = ($urandom_range(0, 99) < 30);
        bus.br_taken   = ($urandom_range(0, 99) < 20);
        bus.br_imm     = 16'($urandom);
        bus.jump       = ($urandom_range(0, 99) < 10);
        bus.jmp_target = 26'($urandom);
`ifdef PC_EXC_EN
        bus.exc_req    = ($urandom_range(0, 99) < 5);
`endif
        @(negedge clk); #1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
